// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bundle between a binary producer and the BCD converter.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 4
);
    logic [BIN_W-1:0]    data_i;
    logic                valid_i;
    logic                ready_o;
    logic [4*DIGITS-1:0] bcd_o;
    logic [DIGITS-1:0]   blank_o;
    logic                ovf_o;
    logic                valid_o;
    modport master (output data_i, valid_i, input ready_o, bcd_o, blank_o, ovf_o, valid_o);
    modport slave  (input data_i, valid_i, output ready_o, bcd_o, blank_o, ovf_o, valid_o);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per cycle, saturating at 10**DIGITS-1.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 4
) (
    input logic          clk_i,
    input logic          rst_i,
    bin2bcd_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    localparam int CW = $clog2(BIN_W + 1);
    localparam int DW = 4 * DIGITS;
    localparam int SW = DW + BIN_W;
    localparam logic [63:0] MAX = 64'(10 ** DIGITS) - 64'd1;
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};
    state_t              state_q, state_d;
    logic [SW-1:0]       sh_q, sh_d, adj;
    logic [CW-1:0]       cnt_q;
    logic                ovf_pend_q, ovf_q, vld_q, over, accept, allz;
    logic [DW-1:0]       bcd_q;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [BIN_W-1:0]    clamp;
    assign over   = 64'(bus.data_i) > MAX;
    assign clamp  = over ? BIN_W'(MAX) : bus.data_i;
    assign accept = bus.valid_i && state_q == IDLE;
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == IDLE ? (accept ? CONV : IDLE)
                : state_q == CONV ? (cnt_q == CW'(BIN_W - 1) ? DONE : CONV)
                : IDLE;
    end
    always_comb begin
        bus.ready_o = state_q == IDLE;
        bus.bcd_o   = bcd_q;
        bus.blank_o = blank_q;
        bus.ovf_o   = ovf_q;
        bus.valid_o = vld_q;
    end
    // Add-3 correction on every nibble before the shift keeps each digit within 0..9.
    always_comb begin
        adj = sh_q;
        for (int k = 0; k < DIGITS; k++)
            adj[BIN_W+4*k +: 4] = sh_q[BIN_W+4*k +: 4] >= 4'd5 ? sh_q[BIN_W+4*k +: 4] + 4'd3 : sh_q[BIN_W+4*k +: 4];
        sh_d = adj << 1;
    end
    always_comb begin
        blank_d = '0;
        allz    = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            allz       = allz && sh_q[BIN_W+4*k +: 4] == 4'd0;
            blank_d[k] = allz;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q       <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= BLANK_RST;
            ovf_q      <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            vld_q <= state_q == DONE;
            if (accept) begin
                sh_q       <= {{DW{1'b0}}, clamp};
                cnt_q      <= '0;
                ovf_pend_q <= over;
            end else if (state_q == CONV) begin
                sh_q  <= sh_d;
                cnt_q <= cnt_q + CW'(1);
            end
            if (state_q == DONE) begin
                bcd_q   <= sh_q[SW-1 -: DW];
                blank_q <= blank_d;
                ovf_q   <= ovf_pend_q;
            end
        end
    end
endmodule
